// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default sizes for the memory arbiter slice.
//   state_t       arbiter FSM states (IDLE -> ISSUE -> CAPTURE -> ACK)
//   DEF_N_CORES   default number of requesters (power of two, >= 2)
//   DEF_ADDR_W    default memory address width
//   DEF_DATA_W    default memory data width
package mem_arb_pkg;

   localparam int unsigned DEF_N_CORES = 4;
   localparam int unsigned DEF_ADDR_W  = 16;
   localparam int unsigned DEF_DATA_W  = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_ACK     = 2'd3
   } state_t;

endpackage

// File: rtl/mem_arb_picker.sv
// mem_arb_picker: combinational winner selection.
// Searches req starting at (pointer + 1) mod N_CORES upward with wrap-around
// and returns the first requester found.
//   req      in   N_CORES  request vector
//   pointer  in   IDX_W    index of the previous grant (search starts after it)
//   idx      out  IDX_W    winning index (0 when any = 0)
//   any      out  1        at least one request is pending
module mem_arb_picker
   import mem_arb_pkg::*;
#(
   parameter  int unsigned N_CORES = DEF_N_CORES,
   localparam int unsigned IDX_W   = $clog2(N_CORES)
) (
   input  logic [N_CORES-1:0] req,
   input  logic [IDX_W-1:0]   pointer,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   logic [IDX_W-1:0] cand;

   // Walk from the farthest candidate back to the nearest so the nearest
   // pending request after the pointer is the last one written.
   always_comb begin
      idx  = '0;
      any  = 1'b0;
      cand = '0;
      for (int i = int'(N_CORES) - 1; i >= 0; i--) begin
         cand = pointer + IDX_W'(i) + IDX_W'(1);
         if (req[cand]) begin
            idx = cand;
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: N-core arbiter in front of a synchronous single-port memory
// with 1-cycle read latency. One access every 4 cycles:
//   IDLE (sample req, latch winner) -> ISSUE (drive memory) ->
//   CAPTURE (read data arrives, load rdata) -> ACK (one-cycle ack pulse).
// Build option: define MEM_ARBITER_ROUND_ROBIN_EN for round-robin
// arbitration; otherwise fixed priority, lowest index wins.
//   clk        in   1                 rising-edge clock
//   reset      in   1                 asynchronous, active-low
//   req, we    in   N_CORES           per-core request / write enable
//   addr       in   N_CORES*ADDR_W    per-core address (core i at slice i)
//   wdata      in   N_CORES*DATA_W    per-core write data
//   ack        out  N_CORES           one-cycle completion pulse
//   rdata      out  N_CORES*DATA_W    per-core registered read data
//   busy       out  1                 FSM not in IDLE
//   mem_addr   out  ADDR_W            memory address
//   mem_wdata  out  DATA_W            memory write data
//   mem_wren   out  1                 memory write strobe (ISSUE only)
//   mem_rdata  in   DATA_W            memory read data
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned N_CORES = DEF_N_CORES,
   parameter int unsigned ADDR_W  = DEF_ADDR_W,
   parameter int unsigned DATA_W  = DEF_DATA_W
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_CORES-1:0]        req,
   input  logic [N_CORES-1:0]        we,
   input  logic [N_CORES*ADDR_W-1:0] addr,
   input  logic [N_CORES*DATA_W-1:0] wdata,
   output logic [N_CORES-1:0]        ack,
   output logic [N_CORES*DATA_W-1:0] rdata,
   output logic                      busy,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_wdata,
   output logic                      mem_wren,
   input  logic [DATA_W-1:0]         mem_rdata
);

   localparam int unsigned IDX_W = $clog2(N_CORES);

   state_t           state;
   logic [IDX_W-1:0] win_idx;
   logic             win_we;
   logic [IDX_W-1:0] pick_ptr;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_any;

   mem_arb_picker #(
      .N_CORES (N_CORES)
   ) u_picker (
      .req     (req),
      .pointer (pick_ptr),
      .idx     (pick_idx),
      .any     (pick_any)
   );

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
   logic [IDX_W-1:0] ptr_q;

   assign pick_ptr = ptr_q;

   // Grant pointer: remembers the last winner so the search starts after it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr_q <= IDX_W'(N_CORES - 1);
      end else if (state == ST_IDLE && pick_any) begin
         ptr_q <= pick_idx;
      end
   end
`else
   // Searching from just past the top index makes index 0 the highest priority.
   assign pick_ptr = IDX_W'(N_CORES - 1);
`endif

   // Arbiter FSM with registered memory-side and core-side outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         win_idx   <= '0;
         win_we    <= 1'b0;
         ack       <= '0;
         busy      <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wren  <= 1'b0;
         rdata     <= '0;
      end else begin
         ack      <= '0;
         mem_wren <= 1'b0;
         case (state)
            ST_IDLE: begin
               // Latch the winner's request; mem_* hold otherwise.
               if (pick_any) begin
                  state     <= ST_ISSUE;
                  busy      <= 1'b1;
                  win_idx   <= pick_idx;
                  win_we    <= we[pick_idx];
                  mem_wren  <= we[pick_idx];
                  mem_addr  <= addr[32'(pick_idx) * ADDR_W +: ADDR_W];
                  mem_wdata <= wdata[32'(pick_idx) * DATA_W +: DATA_W];
               end
            end
            ST_ISSUE: begin
               state <= ST_CAPTURE;
            end
            ST_CAPTURE: begin
               // Memory read data is valid this cycle.
               state        <= ST_ACK;
               ack[win_idx] <= 1'b1;
               if (!win_we) begin
                  rdata[32'(win_idx) * DATA_W +: DATA_W] <= mem_rdata;
               end
            end
            ST_ACK: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed plus randomized self-checking bench for mem_arbiter.
// A behavioural memory sits on the memory port; a transaction-level model
// (shadow memory, expected read data, arbitration rule) predicts every result.
module tb_mem_arbiter;

   localparam int N  = 4;
   localparam int AW = 16;
   localparam int DW = 16;

   logic            clk;
   logic            reset;
   logic [N-1:0]    req;
   logic [N-1:0]    we;
   logic [AW-1:0]   addr_a  [N];
   logic [DW-1:0]   wdata_a [N];
   logic [N*AW-1:0] addr;
   logic [N*DW-1:0] wdata;
   logic [N-1:0]    ack;
   logic [N*DW-1:0] rdata;
   logic            busy;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata;
   logic            mem_wren;
   logic [DW-1:0]   mem_rdata;

   // backdoor preload port of the behavioural memory
   logic            bd_we;
   logic [AW-1:0]   bd_addr;
   logic [DW-1:0]   bd_data;

   logic [DW-1:0]   ram    [0:65535];
   logic [DW-1:0]   shadow [0:65535];
   logic [DW-1:0]   exp_rd [N];
   int              last_grant;
   int              cyc;
   int              tests;
   int              fails;

   for (genvar g = 0; g < N; g++) begin : g_pack
      assign addr[g*AW +: AW]  = addr_a[g];
      assign wdata[g*DW +: DW] = wdata_a[g];
   end

   mem_arbiter #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .we        (we),
      .addr      (addr),
      .wdata     (wdata),
      .ack       (ack),
      .rdata     (rdata),
      .busy      (busy),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wren  (mem_wren),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // synchronous single-port memory, 1-cycle read latency
   always @(posedge clk) begin
      if (bd_we) ram[bd_addr] <= bd_data;
      else if (mem_wren) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [N*DW-1:0] pack_rd();
      logic [N*DW-1:0] v;
      for (int i = 0; i < N; i++) v[i*DW +: DW] = exp_rd[i];
      return v;
   endfunction

   // Arbitration rule, stated directly.
   function automatic int pick(input logic [N-1:0] r);
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      for (int k = 1; k <= N; k++) begin
         if (r[(last_grant + k) % N]) return (last_grant + k) % N;
      end
`else
      for (int c = 0; c < N; c++) begin
         if (r[c]) return c;
      end
`endif
      return -1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) exp_rd[i] = '0;
      last_grant = N - 1;
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
      bd_addr   = a;
      bd_data   = d;
      bd_we     = 1'b1;
      shadow[a] = d;
      tick();
      bd_we     = 1'b0;
   endtask

   // One complete access starting from an IDLE negedge with req already set.
   task automatic serve_one(input bit rereq, input bit scramble, input bit drop_mid,
                            output int w, output int ack_cyc);
      logic          e_we;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wd;
      logic [N-1:0]  oh;
      ack_cyc = 0;
      w = pick(req);
      if (w < 0) begin
         tests++;
         fails++;
         $error("FAIL serve_no_request: observed req=%0h required nonzero", req);
         w = 0;
         return;
      end
      e_we       = we[w];
      e_addr     = addr_a[w];
      e_wd       = wdata_a[w];
      last_grant = w;
      tick();  // ISSUE
      check("issue_busy", 64'(busy), 64'd1);
      check("issue_wren", 64'(mem_wren), 64'(e_we));
      check("issue_addr", 64'(mem_addr), 64'(e_addr));
      if (e_we) check("issue_wdata", 64'(mem_wdata), 64'(e_wd));
      check("issue_ack", 64'(ack), 64'd0);
      if (scramble) begin
         addr_a[w]  = AW'($urandom_range(0, 63));
         wdata_a[w] = DW'($urandom);
         we[w]      = ~we[w];
      end
      if (drop_mid) req[w] = 1'b0;
      tick();  // CAPTURE
      check("capture_wren", 64'(mem_wren), 64'd0);
      check("capture_ack", 64'(ack), 64'd0);
      if (e_we) shadow[e_addr] = e_wd;
      else exp_rd[w] = shadow[e_addr];
      tick();  // ACK
      oh    = '0;
      oh[w] = 1'b1;
      check("ack_onehot", 64'(ack), 64'(oh));
      check("ack_rdata", 64'(rdata), 64'(pack_rd()));
      check("ack_wren", 64'(mem_wren), 64'd0);
      ack_cyc = cyc;
      req[w]  = 1'b0;
      tick();  // IDLE
      check("idle_ack", 64'(ack), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);
      if (rereq) req[w] = 1'b1;
   endtask

   initial begin
      int w, ac, prev_ac, exp_w;
      tests = 0;
      fails = 0;
      reset = 1'b0;
      req   = '0;
      we    = '0;
      bd_we = 1'b0;
      bd_addr = '0;
      bd_data = '0;
      for (int i = 0; i < N; i++) begin
         addr_a[i]  = '0;
         wdata_a[i] = '0;
      end
      model_reset();

      // reset values
      tick();
      tick();
      check("rst_ack", 64'(ack), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_wren", 64'(mem_wren), 64'd0);
      check("rst_maddr", 64'(mem_addr), 64'd0);
      check("rst_mwdata", 64'(mem_wdata), 64'd0);
      check("rst_rdata", 64'(rdata), 64'd0);
      reset = 1'b1;
      tick();

      for (int a = 0; a < 64; a++) preload(AW'(a), DW'($urandom));
      preload(16'h0010, 16'hBEEF);

      // single read by core 2
      we[2] = 1'b0; addr_a[2] = 16'h0010; req[2] = 1'b1;
      serve_one(0, 0, 0, w, ac);
      check("read_winner", 64'(w), 64'd2);
      check("read_beef", 64'(rdata[2*DW +: DW]), 64'hBEEF);

      // single write by core 1, then read back by core 0
      we[1] = 1'b1; addr_a[1] = 16'h0020; wdata_a[1] = 16'h1234; req[1] = 1'b1;
      serve_one(0, 0, 0, w, ac);
      check("write_idle_wren", 64'(mem_wren), 64'd0);
      check("write_hold_addr", 64'(mem_addr), 64'h0020);
      we[0] = 1'b0; addr_a[0] = 16'h0020; req[0] = 1'b1;
      serve_one(0, 0, 0, w, ac);
      check("readback_1234", 64'(rdata[0 +: DW]), 64'h1234);

      // idle hold: no request leaves memory port unchanged
      tick();
      check("hold_addr", 64'(mem_addr), 64'h0020);
      check("hold_busy", 64'(busy), 64'd0);

      // contention from reset
      reset = 1'b0;
      tick();
      reset = 1'b1;
      model_reset();
      tick();
      for (int i = 0; i < N; i++) begin
         we[i] = 1'b0;
         addr_a[i] = AW'(i);
      end
      req = '1;
      prev_ac = 0;
      for (int k = 0; k < N; k++) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
         serve_one(0, 0, 0, w, ac);
         exp_w = k;
`else
         serve_one(1, 0, 0, w, ac);
         exp_w = 0;
`endif
         check("contend_order", 64'(w), 64'(exp_w));
         if (k > 0) check("contend_spacing", 64'(ac - prev_ac), 64'd4);
         prev_ac = ac;
      end
      for (int k = 0; k < 2 * N && req != '0; k++) serve_one(0, 0, 0, w, ac);
      check("contend_drained", 64'(req), 64'd0);

      // core 3 changes addr and drops req during ISSUE
      we[3] = 1'b0; addr_a[3] = 16'h0010; req[3] = 1'b1;
      serve_one(0, 1, 1, w, ac);
      check("mid_winner", 64'(w), 64'd3);
      check("mid_rdata", 64'(rdata[3*DW +: DW]), 64'hBEEF);
      tick();
      check("mid_no_rerun", 64'(busy), 64'd0);

      // reset during CAPTURE of a read
      we[0] = 1'b0; addr_a[0] = 16'h0020; req[0] = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      req[0] = 1'b0;
      #1;
      check("rstmid_ack", 64'(ack), 64'd0);
      check("rstmid_busy", 64'(busy), 64'd0);
      check("rstmid_rdata", 64'(rdata), 64'd0);
      @(negedge clk);
      check("rstmid_no_ack", 64'(ack), 64'd0);
      reset = 1'b1;
      model_reset();
      tick();
      we[2] = 1'b0; addr_a[2] = 16'h0010; req[2] = 1'b1;
      serve_one(0, 0, 0, w, ac);
      check("post_rst_read", 64'(rdata[2*DW +: DW]), 64'hBEEF);

      // reset during ISSUE of a write: the write must not land
      we[1] = 1'b1; addr_a[1] = 16'h0030; wdata_a[1] = ~shadow[16'h0030]; req[1] = 1'b1;
      tick();
      check("wabort_wren_on", 64'(mem_wren), 64'd1);
      reset = 1'b0;
      req[1] = 1'b0;
      #1;
      check("wabort_wren_off", 64'(mem_wren), 64'd0);
      tick();
      reset = 1'b1;
      model_reset();
      tick();
      we[1] = 1'b0; addr_a[1] = 16'h0030; req[1] = 1'b1;
      serve_one(0, 0, 0, w, ac);
      check("wabort_mem_kept", 64'(rdata[1*DW +: DW]), 64'(shadow[16'h0030]));

      // randomized bursts of simultaneous requests
      for (int it = 0; it < 30; it++) begin
         logic [N-1:0] r;
         r = N'($urandom_range(1, (1 << N) - 1));
         for (int i = 0; i < N; i++) begin
            if (r[i]) begin
               we[i]      = 1'($urandom);
               addr_a[i]  = AW'($urandom_range(0, 63));
               wdata_a[i] = DW'($urandom);
            end
         end
         req = r;
         for (int k = 0; k < N && req != '0; k++) serve_one(0, 1'($urandom), 0, w, ac);
         check("rand_drained", 64'(req), 64'd0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
